// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath.
// The sequencer (master) reads the opcode and memory handshake and drives
// every datapath strobe and mux select.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       bne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, bne, pc_source, iord, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, state, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, bne, pc_source, iord, mem_read,
               mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
               alu_src_a, alu_src_b, alu_op, state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath. Each instruction is
// spread over fetch/decode/execute/memory/writeback states so one ALU and
// one unified memory port are shared. Memory states stall on mem_ready.
module multicycle_control (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    state_t state_q;
    state_t state_d;
    // Held low for one cycle after reset release so the first fetch is
    // issued only once the sequencer has seen a clean clock edge.
    logic   started;

    // State register and start-up flag; state only advances once started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started) begin
                state_q <= state_d;
            end
        end
    end

    assign bus.state = state_q;

    // Next-state and Moore outputs; everything is forced to 0 until started.
    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.bne           = 1'b0;
        bus.pc_source     = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        if (started) begin
            case (state_q)
                FETCH: begin
                    // PC+4 computed every fetch cycle; committed only when
                    // the instruction word actually arrives.
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.alu_op    = 2'b10;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = DECODE;
                    end
                end
                DECODE: begin
                    // Speculatively form the branch target into ALUOut.
                    bus.alu_src_b = 2'b11;
                    bus.alu_op    = 2'b10;
                    case (bus.opcode)
                        OP_RTYPE:        state_d = R_EXEC;
                        OP_LW, OP_SW:    state_d = MEM_ADDR;
                        OP_BEQ, OP_BNE:  state_d = BRANCH;
                        OP_J:            state_d = JUMP;
                        OP_ADDI, OP_LUI: state_d = I_EXEC;
                        default: begin
                            bus.illegal_op = 1'b1;
                            state_d        = FETCH;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = 2'b10;
                    if (bus.opcode == OP_LW) begin
                        state_d = MEM_RD;
                    end else if (bus.opcode == OP_SW) begin
                        state_d = MEM_WR;
                    end else begin
                        state_d = FETCH;
                    end
                end
                MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) begin
                        state_d = MEM_WB;
                    end
                end
                MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                    if (bus.mem_ready) begin
                        bus.instr_done = 1'b1;
                        state_d        = FETCH;
                    end
                end
                R_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    state_d       = R_WB;
                end
                R_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                BRANCH: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_source     = 2'b01;
                    bus.pc_write_cond = (bus.opcode == OP_BEQ);
                    bus.bne           = (bus.opcode == OP_BNE);
                    bus.instr_done    = 1'b1;
                    state_d           = FETCH;
                end
                JUMP: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                I_EXEC: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                    bus.alu_op    = (bus.opcode == OP_LUI) ? 2'b11 : 2'b10;
                    state_d       = I_WB;
                end
                I_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The stimulus process drives one
// cycle of inputs and queues the hand-written expected output word for that
// cycle; the monitor samples on the falling edge and checks against the queue.
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {pc_write, pc_write_cond, bne, pc_source, iord, mem_read,
    // mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
    // alu_src_b, alu_op, state, instr_done, illegal_op}
    function automatic logic [22:0] v(
        input bit pcw, input bit pcwc, input bit bn, input int pcs,
        input bit iord, input bit mrd, input bit mwr, input bit irw,
        input bit m2r, input bit rdst, input bit rwr, input bit asa,
        input int asb, input int aop, input int st, input bit done,
        input bit ill);
        logic [1:0] pcs2, asb2, aop2;
        logic [3:0] st4;
        pcs2 = pcs[1:0];
        asb2 = asb[1:0];
        aop2 = aop[1:0];
        st4  = st[3:0];
        return {pcw, pcwc, bn, pcs2, iord, mrd, mwr, irw, m2r, rdst, rwr,
                asa, asb2, aop2, st4, done, ill};
    endfunction

    //                               pcw pcwc bne pcs iord mrd mwr irw m2r rdst rwr asa asb aop st done ill
    localparam logic [22:0] IDLE    = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  0,  0,  0,  0, 0,   0);
    localparam logic [22:0] FETCH_W = v(0, 0,  0,  0,  0,   1,  0,  0,  0,  0,   0,  0,  1,  2,  0, 0,   0);
    localparam logic [22:0] FETCH_R = v(1, 0,  0,  0,  0,   1,  0,  1,  0,  0,   0,  0,  1,  2,  0, 0,   0);
    localparam logic [22:0] DEC     = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  0,  3,  2,  1, 0,   0);
    localparam logic [22:0] DEC_ILL = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  0,  3,  2,  1, 0,   1);
    localparam logic [22:0] M_ADDR  = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  1,  2,  2,  2, 0,   0);
    localparam logic [22:0] M_RD    = v(0, 0,  0,  0,  1,   1,  0,  0,  0,  0,   0,  0,  0,  0,  3, 0,   0);
    localparam logic [22:0] M_WB    = v(0, 0,  0,  0,  0,   0,  0,  0,  1,  0,   1,  0,  0,  0,  4, 1,   0);
    localparam logic [22:0] M_WR_W  = v(0, 0,  0,  0,  1,   0,  1,  0,  0,  0,   0,  0,  0,  0,  5, 0,   0);
    localparam logic [22:0] M_WR_R  = v(0, 0,  0,  0,  1,   0,  1,  0,  0,  0,   0,  0,  0,  0,  5, 1,   0);
    localparam logic [22:0] R_EX    = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  1,  0,  0,  6, 0,   0);
    localparam logic [22:0] R_WBK   = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  1,   1,  0,  0,  0,  7, 1,   0);
    localparam logic [22:0] BR_EQ   = v(0, 1,  0,  1,  0,   0,  0,  0,  0,  0,   0,  1,  0,  1,  8, 1,   0);
    localparam logic [22:0] BR_NE   = v(0, 0,  1,  1,  0,   0,  0,  0,  0,  0,   0,  1,  0,  1,  8, 1,   0);
    localparam logic [22:0] JMP     = v(1, 0,  0,  2,  0,   0,  0,  0,  0,  0,   0,  0,  0,  0,  9, 1,   0);
    localparam logic [22:0] I_ADDI  = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  1,  2,  2, 10, 0,   0);
    localparam logic [22:0] I_LUI   = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   0,  1,  2,  3, 10, 0,   0);
    localparam logic [22:0] I_WBK   = v(0, 0,  0,  0,  0,   0,  0,  0,  0,  0,   1,  0,  0,  0, 11, 1,   0);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        logic [22:0] word;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [22:0] actual_word();
        return {bus.pc_write, bus.pc_write_cond, bus.bne, bus.pc_source,
                bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.state, bus.instr_done,
                bus.illegal_op};
    endfunction

    // Monitor: every falling edge with a pending expectation is one check.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [22:0] act;
            e   = exp_q.pop_front();
            act = actual_word();
            n_tests++;
            if (act !== e.word) begin
                n_fail++;
                $display("FAIL %s: got %06h expected %06h", e.tag, act, e.word);
            end
        end
    end

    // One clock cycle of stimulus plus its expected outputs.
    task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                       input logic [22:0] e, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.opcode    = op;
        bus.mem_ready = mr;
        x.word = e;
        x.tag  = tag;
        exp_q.push_back(x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = OP_R;
        bus.mem_ready = 1'b1;

        // Reset held, then one idle cycle after release, then an R-type.
        for (int i = 0; i < 3; i++) cyc(1'b0, OP_R, 1'b1, IDLE, "reset");
        cyc(1'b1, OP_R, 1'b1, IDLE,    "idle_after_release");
        cyc(1'b1, OP_R, 1'b1, FETCH_R, "r_fetch");
        cyc(1'b1, OP_R, 1'b1, DEC,     "r_decode");
        cyc(1'b1, OP_R, 1'b1, R_EX,    "r_exec");
        cyc(1'b1, OP_R, 1'b1, R_WBK,   "r_wb");

        // lw with 2 fetch wait cycles and 3 memory wait cycles.
        cyc(1'b1, OP_LW, 1'b0, FETCH_W, "lw_fetch_wait0");
        cyc(1'b1, OP_LW, 1'b0, FETCH_W, "lw_fetch_wait1");
        cyc(1'b1, OP_LW, 1'b1, FETCH_R, "lw_fetch");
        cyc(1'b1, OP_LW, 1'b0, DEC,     "lw_decode");
        cyc(1'b1, OP_LW, 1'b0, M_ADDR,  "lw_addr");
        for (int i = 0; i < 3; i++) cyc(1'b1, OP_LW, 1'b0, M_RD, "lw_rd_wait");
        cyc(1'b1, OP_LW, 1'b1, M_RD,    "lw_rd");
        cyc(1'b1, OP_LW, 1'b1, M_WB,    "lw_wb");

        // sw, zero-wait.
        cyc(1'b1, OP_SW, 1'b1, FETCH_R, "sw_fetch");
        cyc(1'b1, OP_SW, 1'b1, DEC,     "sw_decode");
        cyc(1'b1, OP_SW, 1'b1, M_ADDR,  "sw_addr");
        cyc(1'b1, OP_SW, 1'b1, M_WR_R,  "sw_wr");

        // Branches and jump.
        cyc(1'b1, OP_BEQ, 1'b1, FETCH_R, "beq_fetch");
        cyc(1'b1, OP_BEQ, 1'b1, DEC,     "beq_decode");
        cyc(1'b1, OP_BEQ, 1'b1, BR_EQ,   "beq_branch");
        cyc(1'b1, OP_BNE, 1'b1, FETCH_R, "bne_fetch");
        cyc(1'b1, OP_BNE, 1'b1, DEC,     "bne_decode");
        cyc(1'b1, OP_BNE, 1'b1, BR_NE,   "bne_branch");
        cyc(1'b1, OP_J,   1'b1, FETCH_R, "j_fetch");
        cyc(1'b1, OP_J,   1'b1, DEC,     "j_decode");
        cyc(1'b1, OP_J,   1'b1, JMP,     "j_jump");

        // addi then lui.
        cyc(1'b1, OP_ADDI, 1'b1, FETCH_R, "addi_fetch");
        cyc(1'b1, OP_ADDI, 1'b1, DEC,     "addi_decode");
        cyc(1'b1, OP_ADDI, 1'b1, I_ADDI,  "addi_exec");
        cyc(1'b1, OP_ADDI, 1'b1, I_WBK,   "addi_wb");
        cyc(1'b1, OP_LUI,  1'b1, FETCH_R, "lui_fetch");
        cyc(1'b1, OP_LUI,  1'b1, DEC,     "lui_decode");
        cyc(1'b1, OP_LUI,  1'b1, I_LUI,   "lui_exec");
        cyc(1'b1, OP_LUI,  1'b1, I_WBK,   "lui_wb");

        // Illegal opcode returns straight to fetch.
        cyc(1'b1, OP_BAD, 1'b1, FETCH_R, "ill_fetch");
        cyc(1'b1, OP_BAD, 1'b1, DEC_ILL, "ill_decode");
        cyc(1'b1, OP_R,   1'b1, FETCH_R, "ill_next_fetch");
        cyc(1'b1, OP_R,   1'b1, DEC,     "after_ill_decode");
        cyc(1'b1, OP_R,   1'b1, R_EX,    "after_ill_exec");
        cyc(1'b1, OP_R,   1'b1, R_WBK,   "after_ill_wb");

        // Reset asserted while a store waits on memory.
        cyc(1'b1, OP_SW, 1'b1, FETCH_R, "swr_fetch");
        cyc(1'b1, OP_SW, 1'b0, DEC,     "swr_decode");
        cyc(1'b1, OP_SW, 1'b0, M_ADDR,  "swr_addr");
        cyc(1'b1, OP_SW, 1'b0, M_WR_W,  "swr_wr_wait");
        cyc(1'b0, OP_SW, 1'b0, IDLE,    "swr_async_reset");
        cyc(1'b0, OP_SW, 1'b1, IDLE,    "swr_reset_hold");
        cyc(1'b1, OP_R,  1'b1, IDLE,    "swr_idle_after_release");
        cyc(1'b1, OP_R,  1'b1, FETCH_R, "restart_fetch");
        cyc(1'b1, OP_R,  1'b1, DEC,     "restart_decode");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencer for the multi-cycle MIPS datapath. It replaces the single-cycle opcode decoder with a state machine that spreads each instruction over fetch, decode, execute, memory and writeback cycles. This lets one ALU and one unified memory port be shared across cycles. It supports R-type, lw, sw, beq, bne, addi, j and lui, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `mem_ready` in 1: memory access completes this cycle; zero-wait allowed.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero (beq).
- `bne` out 1: PC load if ALU not zero.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `iord` out 1: memory address 0=PC, 1=ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1.
- `mem_to_reg`, `reg_dst`, `reg_write` out 1.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `alu_op` out 2: 00 funct, 01 subtract, 10 add, 11 lui/pass.
- `state` out 4: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final cycle of a retired instruction.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11. Encodings 12-15 are unreachable and recover to FETCH.
- Any strobe not listed for a state is 0 in that state. Selects not listed are 0.
- **FETCH**: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=10.
  - ir_write and pc_write (pc_source=00) assert only in the cycle mem_ready=1.
  - Holds in FETCH while mem_ready=0; moves to DECODE on mem_ready.
- **DECODE**: alu_src_a=0, alu_src_b=11, alu_op=10 (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC.
  - 100011 or 101011 -> MEM_ADDR.
  - 000100 or 000101 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 or 001111 -> I_EXEC.
  - Any other opcode -> FETCH with illegal_op=1.
- **MEM_ADDR**: alu_src_a=1, alu_src_b=10, alu_op=10. Goes to MEM_RD for lw, MEM_WR for sw.
- **MEM_RD**: mem_read=1, iord=1. Holds until mem_ready, then MEM_WB.
- **MEM_WB**: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- **MEM_WR**: mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- **R_EXEC**: alu_src_a=1, alu_src_b=00, alu_op=00. Goes to R_WB.
- **R_WB**: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- **BRANCH**: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write_cond=1 for 000100; bne=1 for 000101. Goes to FETCH.
- **JUMP**: pc_write=1, pc_source=10. Goes to FETCH.
- **I_EXEC**: alu_src_a=1, alu_src_b=10. alu_op=10 for addi, 11 for lui. Goes to I_WB.
- **I_WB**: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- `instr_done` asserts in:
  - MEM_WB, R_WB, I_WB, BRANCH and JUMP;
  - MEM_WR in the mem_ready cycle.
  - Never with illegal_op.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Timing
- All outputs are combinational from the registered state and the `started` flag. FETCH strobes are additionally qualified by mem_ready.
- rst_n low: state=FETCH, started=0 asynchronously.
- While started=0, every output is 0 except state=0.
- started sets on the first rising edge after rst_n rises. The first fetch read is therefore issued one cycle after release.
- Reset asserted mid-instruction: all strobes drop immediately and no partial write completes. After release, sequencing restarts at FETCH.
- Latency with zero-wait memory, counted from FETCH entry to instr_done inclusive:
  - R-type, addi, lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, bne, j: 3 cycles.
- Each memory wait cycle adds 1 cycle per access.
- Next FETCH begins the cycle after instr_done or illegal_op.

## Test plan
- Reset held 3 cycles, then released, mem_ready=1, opcode=000000 -> all outputs 0 during reset. One idle cycle after release, then states 0,1,6,7. reg_write=1 and reg_dst=1 in state 7; instr_done in cycle 4.
- lw (100011) with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> ir_write exactly once. States 0,0,0,1,2,3,3,3,3,4; mem_to_reg=1 in state 4.
- sw (101011), zero-wait -> mem_write=1 and iord=1 for one cycle in state 5; reg_write never 1; instr_done in the same cycle.
- Branches:
  - beq -> pc_write_cond=1, bne=0, pc_source=01, alu_op=01 in state 8.
  - bne -> bne=1, pc_write_cond=0.
  - j -> pc_write=1, pc_source=10 in state 9.
- addi, then lui -> alu_src_b=10 in state 10; alu_op=10 for addi, 11 for lui.
- Opcode 111111 -> illegal_op pulse in DECODE; no reg_write, mem_write or pc_write; next cycle is FETCH.
- rst_n pulsed low during MEM_WR with mem_ready=0 -> mem_write drops asynchronously; restart at FETCH.
